io_cond_blink: RTL and testbench

//   Front-end conditioner for asynchronous CPU-side signals in the 100MHz i_clk domain.
//   - Synchronises a vector of async inputs and the CPU clock i_phi through multi-stage flop chains.
//   - Flags rising edges of each synchronised signal as single-cycle pulses.
//   - Drives two free-running heartbeat blinks: one from i_clk, one from counted i_phi rising edges.

---
 rtl/io_cond_pkg.sv | 13 +
 rtl/io_cond_blink_sync_bit.sv | 34 +++
 rtl/io_cond_blink.sv | 112 +++++++++++
 tb/tb_io_cond_blink.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_cond_pkg.sv
// ----------------------------------------------------------------------------
// io_cond_pkg
//   Shared default constants for the io_cond_blink front-end conditioner.
//   Imported by io_cond_blink and its sync_bit synchroniser.
// ----------------------------------------------------------------------------
package io_cond_pkg;

   localparam int DEF_WIDTH          = 4;
   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_BLINK_BITS_CLK = 26;
   localparam int DEF_BLINK_BITS_PHI = 24;

endpackage : io_cond_pkg

// File: rtl/io_cond_blink_sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit
//   Single-bit multi-flop synchroniser into the i_clk domain, cleared by the
//   asynchronous active-low reset.
// Ports
//   i_clk    in   1   sampling clock
//   i_rst_n  in   1   asynchronous active-low clear of every stage
//   i_d      in   1   asynchronous level to synchronise
//   o_q      out  1   last stage of the chain
// ----------------------------------------------------------------------------
module sync_bit
   import io_cond_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = chain[STAGES-1];

endmodule : sync_bit

// File: rtl/io_cond_blink.sv
// ----------------------------------------------------------------------------
// io_cond_blink
//   Front-end conditioner for asynchronous CPU-side signals in the i_clk
//   domain: synchronises a vector of async levels plus the CPU clock i_phi,
//   flags edges as one-cycle pulses, and drives two heartbeat blinks (one
//   free-running on i_clk, one advancing on synchronised i_phi rising edges).
//
// Build option
//   EDGE_FALL_EN  defined   : o_fall pulses on 1->0 of o_sync
//                 undefined : o_fall tied to zero (port kept)
//
// Ports
//   i_clk       in   1      system clock, sole clock of the block
//   i_rst_n     in   1      asynchronous active-low reset
//   i_phi       in   1      CPU clock, asynchronous to i_clk
//   i_async     in   WIDTH  asynchronous level inputs
//   o_sync      out  WIDTH  synchronised copy of i_async
//   o_rise      out  WIDTH  1-cycle pulse on 0->1 of o_sync
//   o_fall      out  WIDTH  1-cycle pulse on 1->0 of o_sync (EDGE_FALL_EN)
//   o_phi_sync  out  1      synchronised i_phi
//   o_phi_rise  out  1      1-cycle pulse on 0->1 of o_phi_sync
//   o_blink1    out  1      MSB of the free-running i_clk counter
//   o_blink2    out  1      MSB of the phi-edge counter
// ----------------------------------------------------------------------------
module io_cond_blink
   import io_cond_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int BLINK_BITS_CLK = DEF_BLINK_BITS_CLK,
   parameter int BLINK_BITS_PHI = DEF_BLINK_BITS_PHI
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_phi,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_phi_sync,
   output logic             o_phi_rise,
   output logic             o_blink1,
   output logic             o_blink2
);

   localparam logic [BLINK_BITS_CLK-1:0] CLK_STEP = BLINK_BITS_CLK'(1);
   localparam logic [BLINK_BITS_PHI-1:0] PHI_STEP = BLINK_BITS_PHI'(1);

   logic [WIDTH-1:0]          sync_prev;
   logic                      phi_prev;
   logic [BLINK_BITS_CLK-1:0] cnt_clk;
   logic [BLINK_BITS_PHI-1:0] cnt_phi;

   for (genvar g = 0; g < WIDTH; g++) begin : g_sync
      sync_bit #(
         .STAGES (SYNC_STAGES)
      ) u_sync_bit (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_d     (i_async[g]),
         .o_q     (o_sync[g])
      );
   end

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync_phi (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_phi),
      .o_q     (o_phi_sync)
   );

   // prev clears to 0, so an input already high at reset release still
   // produces exactly one rise pulse once it reaches o_sync.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_prev <= '0;
         phi_prev  <= 1'b0;
      end else begin
         sync_prev <= o_sync;
         phi_prev  <= o_phi_sync;
      end
   end

   assign o_rise     = o_sync & ~sync_prev;
   assign o_phi_rise = o_phi_sync & ~phi_prev;

`ifdef EDGE_FALL_EN
   assign o_fall = ~o_sync & sync_prev;
`else
   assign o_fall = '0;
`endif

   // Both counters wrap naturally; the phi counter only moves on a detected
   // edge, so a stopped i_phi freezes o_blink2.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_clk <= '0;
         cnt_phi <= '0;
      end else begin
         cnt_clk <= cnt_clk + CLK_STEP;
         if (o_phi_rise) begin
            cnt_phi <= cnt_phi + PHI_STEP;
         end
      end
   end

   assign o_blink1 = cnt_clk[BLINK_BITS_CLK-1];
   assign o_blink2 = cnt_phi[BLINK_BITS_PHI-1];

endmodule : io_cond_blink

// File: tb/tb_io_cond_blink.sv
// ----------------------------------------------------------------------------
// tb_io_cond_blink
//   Scoreboard bench for io_cond_blink (WIDTH=4, BLINK_BITS_CLK=4,
//   BLINK_BITS_PHI=3). Stimulus pushes expected edge events (cycle, value);
//   a negedge monitor pops and compares whenever the DUT shows a pulse, and
//   checks both blinks every cycle against cycle/edge counts.
// ----------------------------------------------------------------------------
module tb_io_cond_blink;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       phi = 1'b0;
   logic [3:0] async_in = 4'h0;

   logic [3:0] o_sync, o_rise, o_fall;
   logic       o_phi_sync, o_phi_rise, o_blink1, o_blink2;

   io_cond_blink #(
      .WIDTH          (4),
      .SYNC_STAGES    (2),
      .BLINK_BITS_CLK (4),
      .BLINK_BITS_PHI (3)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_phi      (phi),
      .i_async    (async_in),
      .o_sync     (o_sync),
      .o_rise     (o_rise),
      .o_fall     (o_fall),
      .o_phi_sync (o_phi_sync),
      .o_phi_rise (o_phi_rise),
      .o_blink1   (o_blink1),
      .o_blink2   (o_blink2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [3:0] val;
      logic [3:0] sync;
   } ev_t;

   ev_t  rise_q[$];
   ev_t  fall_q[$];
   int   phi_q[$];
   ev_t  mon_e;
   int   mon_t;

   int         errors = 0;
   int         checks = 0;
   int         cyc_rel = 0;
   int         phi_cnt = 0;
   logic [3:0] cur = 4'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: outputs settle after the posedge, sampled on the negedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         phi_cnt = 0;
      end else begin
         chk("blink1", {31'd0, o_blink1}, {31'd0, ((cyc - cyc_rel) % 16) >= 8});
         chk("blink2", {31'd0, o_blink2}, {31'd0, (phi_cnt % 8) >= 4});
         if (o_rise != 4'h0) begin
            if (rise_q.size() == 0) begin
               chk("rise_unexpected", {28'd0, o_rise}, 32'd0);
            end else begin
               mon_e = rise_q.pop_front();
               chk("rise_val", {28'd0, o_rise}, {28'd0, mon_e.val});
               chk("rise_cyc", cyc, mon_e.t);
               chk("rise_sync", {28'd0, o_sync}, {28'd0, mon_e.sync});
            end
         end
`ifdef EDGE_FALL_EN
         if (o_fall != 4'h0) begin
            if (fall_q.size() == 0) begin
               chk("fall_unexpected", {28'd0, o_fall}, 32'd0);
            end else begin
               mon_e = fall_q.pop_front();
               chk("fall_val", {28'd0, o_fall}, {28'd0, mon_e.val});
               chk("fall_cyc", cyc, mon_e.t);
               chk("fall_sync", {28'd0, o_sync}, {28'd0, mon_e.sync});
            end
         end
`else
         chk("fall_off", {28'd0, o_fall}, 32'd0);
`endif
         if (o_phi_rise) begin
            if (phi_q.size() == 0) begin
               chk("phi_unexpected", 32'd1, 32'd0);
            end else begin
               mon_t = phi_q.pop_front();
               chk("phi_rise_cyc", cyc, mon_t);
            end
            phi_cnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic check_all_zero(input string name);
      chk(name, {21'd0, o_sync, o_rise, o_fall, o_phi_sync, o_phi_rise, o_blink1, o_blink2}, 32'd0);
   endtask

   task automatic set_async(input logic [3:0] v);
      if ((v & ~cur) != 4'h0) rise_q.push_back('{cyc + 2, v & ~cur, v});
`ifdef EDGE_FALL_EN
      if ((~v & cur) != 4'h0) fall_q.push_back('{cyc + 2, ~v & cur, v});
`endif
      async_in = v;
      cur = v;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      rise_q.delete();
      fall_q.delete();
      phi_q.delete();
      cur = 4'h0;
   endtask

   task automatic release_reset();
      cyc_rel = cyc;
      rst_n = 1'b1;
      if (async_in != 4'h0) rise_q.push_back('{cyc + 2, async_in, async_in});
      cur = async_in;
   endtask

   // One i_phi period at clk/5: high for 2 cycles, low for 3.
   task automatic phi_period();
      phi = 1'b1;
      phi_q.push_back(cyc + 2);
      step(2);
      phi = 1'b0;
      step(3);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 20 && (rise_q.size() + fall_q.size() + phi_q.size()) != 0; i++) step(1);
      chk(name, rise_q.size() + fall_q.size() + phi_q.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with inputs high and i_phi toggling: everything stays 0.
      async_in = 4'hF;
      assert_reset();
      for (int i = 0; i < 6; i++) begin
         phi = ~phi;
         step(1);
         check_all_zero("reset_outs");
      end
      phi = 1'b0;
      step(2);
      check_all_zero("reset_outs_idle");

      // Release with inputs already high: one rise pulse 2 cycles later.
      release_reset();
      step(4);

      // Edge patterns, each allowed to settle.
      set_async(4'h0);    step(4);
      set_async(4'b0101); step(4);
      set_async(4'h0);    step(4);
      set_async(4'b0011); step(4);
      set_async(4'b0110); step(4);
      set_async(4'h0);    step(4);
      wait_drain("edge_drain");
      step(20);

      // Phi counting: 16 edges, blink2 back to 0 (16 mod 8).
      for (int i = 0; i < 16; i++) phi_period();
      step(4);
      wait_drain("phi_drain16");
      chk("phi_pulses_16", phi_cnt, 32'd16);
      chk("blink2_after16", {31'd0, o_blink2}, 32'd0);

      // Five more edges (21 mod 8 = 5 -> high), then i_phi held: frozen.
      for (int i = 0; i < 5; i++) phi_period();
      step(4);
      chk("blink2_after21", {31'd0, o_blink2}, 32'd1);
      step(20);
      chk("blink2_frozen", {31'd0, o_blink2}, 32'd1);
      chk("phi_cnt_frozen", phi_cnt, 32'd21);

      // Mid-run reset for 3 cycles, then counting restarts from 0.
      for (int i = 0; i < 6; i++) phi_period();
      wait_drain("phi_drain_pre_reset");
      assert_reset();
      step(1);
      check_all_zero("midreset_outs_1");
      step(1);
      check_all_zero("midreset_outs_2");
      step(1);
      check_all_zero("midreset_outs_3");
      release_reset();
      step(1);
      chk("blink1_restart", {31'd0, o_blink1}, 32'd0);
      for (int i = 0; i < 5; i++) phi_period();
      step(4);
      wait_drain("phi_drain_post_reset");
      chk("phi_pulses_restart", phi_cnt, 32'd5);
      chk("blink2_restart", {31'd0, o_blink2}, 32'd1);
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_io_cond_blink
